bcd_serial_subtractor: RTL and testbench

BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit_sub.sv | 21 ++
 rtl/bcd_serial_subtractor.sv | 136 +++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the serial BCD subtractor.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int RADIX   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract with borrow in/out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               brw_in,
  output logic [DIGIT_W-1:0] d,
  output logic               brw_out
);

  // One extra bit holds the sign; raw 4-bit inputs keep t within -16..15.
  logic [DIGIT_W:0] t;

  always_comb begin
    t       = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT_W{1'b0}}, brw_in};
    brw_out = t[DIGIT_W];
    d       = brw_out ? (t[DIGIT_W-1:0] + DIGIT_W'(RADIX)) : t[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, one digit per clock, LSD first.
// Optional input digit checking is enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      borrow_in,
  output logic                      ready,
  output logic                      valid,
  output logic [DIGIT_W*DIGITS-1:0] diff,
  output logic                      borrow_out,
  output logic                      invalid
);

  localparam int         W        = DIGIT_W * DIGITS;
  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   diff_q, diff_d;
  logic [3:0]     idx_q, idx_d;
  logic           brw_q, brw_d;

  logic [DIGIT_W-1:0] a_dig, b_dig, d_dig;
  logic               brw_nxt;
  logic               capture;
  logic               in_run;

  assign a_dig   = opa_q[DIGIT_W*int'(idx_q) +: DIGIT_W];
  assign b_dig   = opb_q[DIGIT_W*int'(idx_q) +: DIGIT_W];
  assign capture = (state_q == IDLE) && start;
  assign in_run  = (state_q == RUN);

  bcd_digit_sub u_digit_sub (
    .a_d    (a_dig),
    .b_d    (b_dig),
    .brw_in (brw_q),
    .d      (d_dig),
    .brw_out(brw_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          brw_d   = borrow_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Each digit lands in its own slot, so diff is fully rebuilt by DONE.
        diff_d[DIGIT_W*int'(idx_q) +: DIGIT_W] = d_dig;
        brw_d = brw_nxt;
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign diff       = diff_q;
  assign borrow_out = brw_q;

`ifdef BCD_INPUT_CHECK_EN
  logic inv_q, inv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  always_comb begin
    inv_d = inv_q;
    if (capture) begin
      inv_d = 1'b0;
    end else if (in_run) begin
      inv_d = inv_q | (a_dig > DIGIT_W'(RADIX - 1)) | (b_dig > DIGIT_W'(RADIX - 1));
    end
  end

  assign invalid = inv_q;
`else
  logic unused_ok;
  assign unused_ok = capture ^ in_run;
  assign invalid   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=4).
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

`ifdef BCD_INPUT_CHECK_EN
  localparam logic INV_EXP = 1'b1;
`else
  localparam logic INV_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         borrow_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         valid;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         invalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .ready     (ready),
    .valid     (valid),
    .diff      (diff),
    .borrow_out(borrow_out),
    .invalid   (invalid)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge while idle; returns #1 after the edge that leaves DONE.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bin, input logic [W-1:0] exp_d, input logic exp_b,
                        input logic exp_inv, input logic chk_diff);
    int cyc;
    a = av;
    b = bv;
    borrow_in = bin;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    check({tag, " ready_low"}, W'(ready), W'(1'b0));
    while (valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, W'(cyc), W'(DIGITS + 1));
    if (chk_diff) check({tag, " diff"}, diff, exp_d);
    check({tag, " borrow"}, W'(borrow_out), W'(exp_b));
    check({tag, " invalid"}, W'(invalid), W'(exp_inv));
    check({tag, " ready_done"}, W'(ready), W'(1'b0));
    @(posedge clk);
    #1;
    check({tag, " valid_once"}, W'(valid), W'(1'b0));
    check({tag, " ready_back"}, W'(ready), W'(1'b1));
    if (chk_diff) check({tag, " diff_hold"}, diff, exp_d);
    $display("op %s: a=%h b=%h bin=%0d -> diff=%h bout=%0d inv=%0d cycles=%0d",
             tag, av, bv, bin, diff, borrow_out, invalid, cyc);
  endtask

  initial begin
    int nval;
    int first_v;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", W'(ready), W'(1'b1));
    check("rst valid", W'(valid), W'(1'b0));
    check("rst diff", diff, '0);
    check("rst borrow", W'(borrow_out), W'(1'b0));
    check("rst invalid", W'(invalid), W'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("basic", 16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 1'b1);
    run_op("neg", 16'h0003, 16'h0005, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b1);
    run_op("ripple", 16'h1000, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b1);
    run_op("zero_m1", 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1);
    run_op("all9_b", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
    run_op("nonbcd", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, INV_EXP, 1'b0);

    // start pulsed during RUN must be ignored
    a = 16'h1234;
    b = 16'h0567;
    borrow_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nval = 0;
    first_v = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 2) begin
        a = 16'h9999;
        b = 16'h0000;
        start = 1'b1;
      end
      if (c == 3) start = 1'b0;
      if (valid === 1'b1) begin
        nval++;
        first_v = c;
      end
    end
    check("ign valid_count", W'(nval), W'(1));
    check("ign valid_cycle", W'(first_v), W'(5));
    check("ign diff", diff, 16'h0667);
    @(posedge clk);
    #1;
    check("ign ready_rise", W'(ready), W'(1'b1));
    check("ign no_second_valid", W'(valid), W'(1'b0));
    $display("op ignore: stray start in RUN, valids=%0d at cycle %0d diff=%h", nval, first_v, diff);
    run_op("b2b", 16'h0003, 16'h0005, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b1);

    // reset asserted mid-RUN aborts the operation
    a = 16'h1234;
    b = 16'h0567;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort ready", W'(ready), W'(1'b1));
    check("abort valid", W'(valid), W'(1'b0));
    check("abort diff", diff, '0);
    check("abort borrow", W'(borrow_out), W'(1'b0));
    check("abort invalid", W'(invalid), W'(1'b0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) nval++;
    end
    check("abort no_valid", W'(nval), W'(0));
    check("abort ready_after", W'(ready), W'(1'b1));
    $display("op abort: reset mid-RUN, valids after release=%0d ready=%0d", nval, ready);

    run_op("recover", 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
